// File: rtl/pps_generator.sv
// One-pulse-per-period generator with a one-shot signed phase adjust.
// Outputs a fixed-width pulse, a rise tick and a running pulse count.
module pps_generator #(
  parameter int C_CLOCK_FREQUENCY = 125000,
  parameter int C_PULSE_WIDTH     = 12500,
  parameter int C_ADJ_WIDTH       = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   adj_valid,
  input  logic [C_ADJ_WIDTH-1:0] adj_value,
  output logic                   adj_ready,
  output logic                   pps_out,
  output logic                   pps_tick,
  output logic [31:0]            sec_count
);

  localparam int CNT_W = $clog2(2 * C_CLOCK_FREQUENCY);
  localparam int SUM_W = ((C_ADJ_WIDTH > CNT_W) ? C_ADJ_WIDTH : CNT_W) + 2;

  localparam logic signed [SUM_W-1:0] PER_NOM = SUM_W'(C_CLOCK_FREQUENCY);
  localparam logic signed [SUM_W-1:0] PER_MIN = SUM_W'(C_PULSE_WIDTH + 1);
  localparam logic signed [SUM_W-1:0] PER_MAX = SUM_W'(2 * C_CLOCK_FREQUENCY - 1);
  localparam logic [CNT_W-1:0]        PER_DEF = CNT_W'(C_CLOCK_FREQUENCY);
  localparam logic [CNT_W-1:0]        PW_LAST = CNT_W'(C_PULSE_WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   pps_q, pps_d;
  logic                   tick_q, tick_d;
  logic [31:0]            sec_q, sec_d;
  logic                   pend_q, pend_d;
  logic [C_ADJ_WIDTH-1:0] adj_q, adj_d;

  logic signed [SUM_W-1:0] adj_ext;
  logic signed [SUM_W-1:0] adj_sum;
  logic signed [SUM_W-1:0] adj_sat;
  logic [CNT_W-1:0]        next_period;
  logic                    period_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= PER_DEF;
      pps_q    <= 1'b0;
      tick_q   <= 1'b0;
      sec_q    <= '0;
      pend_q   <= 1'b0;
      adj_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pps_q    <= pps_d;
      tick_q   <= tick_d;
      sec_q    <= sec_d;
      pend_q   <= pend_d;
      adj_q    <= adj_d;
    end
  end

  // Adjusted period is clamped so the pulse always fits and cnt never overflows.
  always_comb begin
    adj_ext = $signed({{(SUM_W - C_ADJ_WIDTH){adj_q[C_ADJ_WIDTH-1]}}, adj_q});
    adj_sum = PER_NOM + adj_ext;
    if (adj_sum < PER_MIN) begin
      adj_sat = PER_MIN;
    end else if (adj_sum > PER_MAX) begin
      adj_sat = PER_MAX;
    end else begin
      adj_sat = adj_sum;
    end
    next_period = pend_q ? CNT_W'(adj_sat) : PER_DEF;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    pps_d        = pps_q;
    tick_d       = 1'b0;
    sec_d        = sec_q;
    pend_d       = pend_q;
    adj_d        = adj_q;
    period_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        pps_d = 1'b0;
        if (enable) begin
          state_d      = ST_RUN;
          period_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pps_d   = 1'b0;
        end else if (cnt_q == period_q - 1'b1) begin
          period_start = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == PW_LAST) begin
            pps_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (period_start) begin
      cnt_d    = '0;
      pps_d    = 1'b1;
      tick_d   = 1'b1;
      sec_d    = sec_q + 32'd1;
      period_d = next_period;
      pend_d   = 1'b0;
    end

    // A transfer only happens while empty, so it never collides with consumption.
    if (adj_valid && !pend_q) begin
      pend_d = 1'b1;
      adj_d  = adj_value;
    end
  end

  assign adj_ready = !pend_q;
  assign pps_out   = pps_q;
  assign pps_tick  = tick_q;
  assign sec_count = sec_q;

endmodule

// File: tb/tb_pps_generator.sv
// Randomized and directed bench for pps_generator against a time-based model
// that tracks period-start instants rather than counter states.
module tb_pps_generator;

  localparam int F  = 100;
  localparam int PW = 10;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          adj_valid;
  logic [AW-1:0] adj_value;
  logic          adj_ready;
  logic          pps_out;
  logic          pps_tick;
  logic [31:0]   sec_count;

  pps_generator #(
    .C_CLOCK_FREQUENCY(F),
    .C_PULSE_WIDTH(PW),
    .C_ADJ_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .adj_valid(adj_valid),
    .adj_value(adj_value),
    .adj_ready(adj_ready),
    .pps_out(pps_out),
    .pps_tick(pps_tick),
    .sec_count(sec_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: absolute edge index of the last period start and its length.
  int          cyc = 0;
  bit          m_run = 0;
  int          m_last = 0;
  int          m_per = F;
  bit          m_pend = 0;
  int          m_adj = 0;
  logic [31:0] m_sec = '0;
  bit          m_tick = 0;
  bit          got_tick = 0;
  int          rises[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int sat_period(input int x);
    if (x < PW + 1) return PW + 1;
    if (x > 2 * F - 1) return 2 * F - 1;
    return x;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_sec = '0; m_tick = 0; m_per = F;
  endtask

  task automatic model_edge();
    bit xfer;
    bit start;
    xfer  = adj_valid && !m_pend;
    start = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (!m_run) start = enable;
      else if (!enable) m_run = 0;
      else if (cyc - m_last == m_per) start = 1;
      if (start) begin
        m_run  = 1;
        m_last = cyc;
        m_per  = m_pend ? sat_period(F + m_adj) : F;
        m_pend = 0;
        m_sec  = m_sec + 32'd1;
      end
      if (xfer) begin
        m_pend = 1;
        m_adj  = int'($signed(adj_value));
      end
      m_tick = start;
    end
    cyc++;
  endtask

  task automatic step();
    bit exp_pps;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_pps = m_run && ((cyc - 1 - m_last) < PW);
    check_eq("pps", 32'(pps_out), 32'(exp_pps));
    check_eq("tick", 32'(pps_tick), 32'(m_tick));
    check_eq("sec", sec_count, m_sec);
    check_eq("rdy", 32'(adj_ready), 32'(!m_pend));
    got_tick = pps_tick;
    if (pps_tick) begin
      rises.push_back(cyc - 1);
      $display("tick sec=%0d at cycle %0d", sec_count, cyc - 1);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ticks(input int k);
    int seen = 0;
    for (int i = 0; i < 1000 && seen < k; i++) begin
      step();
      if (got_tick) seen++;
    end
    if (seen < k) check_eq("tick_timeout", 32'(seen), 32'(k));
  endtask

  task automatic do_adj(input int v);
    adj_valid = 1'b1;
    adj_value = AW'(v);
    step();
    adj_valid = 1'b0;
  endtask

  function automatic int last_iv();
    if (rises.size() < 2) return -1;
    return rises[$] - rises[$-1];
  endfunction

  initial begin
    logic [31:0] sec_b;
    int guard;
    int v;
    rst = 1'b1; enable = 1'b0; adj_valid = 1'b0; adj_value = '0;
    run(2);
    check_eq("rst_pps", 32'(pps_out), 32'd0);
    check_eq("rst_sec", sec_count, 32'd0);
    check_eq("rst_rdy", 32'(adj_ready), 32'd1);
    rst = 1'b0;
    run(3);

    // Basic run: immediate rise, 100-cycle spacing, counts 1,2,3.
    enable = 1'b1;
    step();
    check_eq("first_rise", 32'(pps_out), 32'd1);
    check_eq("first_sec", sec_count, 32'd1);
    wait_ticks(2);
    check_eq("basic_iv", 32'(last_iv()), 32'd100);
    check_eq("basic_sec3", sec_count, 32'd3);

    // Positive adjust mid-period.
    run(30);
    do_adj(5);
    check_eq("adj_rdy_low", 32'(adj_ready), 32'd0);
    wait_ticks(1);
    check_eq("adj_rdy_back", 32'(adj_ready), 32'd1);
    wait_ticks(1);
    check_eq("adj_p105", 32'(last_iv()), 32'd105);
    wait_ticks(1);
    check_eq("adj_p100", 32'(last_iv()), 32'd100);

    // Saturation both ways.
    run(20);
    do_adj(-200);
    wait_ticks(2);
    check_eq("sat_lo", 32'(last_iv()), 32'd11);
    run(3);
    do_adj(500);
    wait_ticks(2);
    check_eq("sat_hi", 32'(last_iv()), 32'd199);

    // Accept on a period-start edge.
    guard = 0;
    while (cyc != m_last + m_per && guard < 300) begin step(); guard++; end
    adj_valid = 1'b1; adj_value = AW'(-3);
    step();
    adj_valid = 1'b0;
    check_eq("tick_acc_tick", 32'(pps_tick), 32'd1);
    wait_ticks(1);
    check_eq("tick_acc_p100", 32'(last_iv()), 32'd100);
    wait_ticks(1);
    check_eq("tick_acc_p97", 32'(last_iv()), 32'd97);

    // Disable at cnt = 5, re-enable 37 cycles later.
    guard = 0;
    while (cyc - 1 - m_last != 5 && guard < 300) begin step(); guard++; end
    sec_b  = m_sec;
    enable = 1'b0;
    step();
    check_eq("dis_pps", 32'(pps_out), 32'd0);
    check_eq("dis_sec", sec_count, sec_b);
    run(36);
    enable = 1'b1;
    step();
    check_eq("reen_pps", 32'(pps_out), 32'd1);
    check_eq("reen_sec", sec_count, sec_b + 32'd1);

    // Async reset mid-pulse with an adjust pending.
    do_adj(7);
    guard = 0;
    while (cyc - 1 - m_last != 3 && guard < 300) begin step(); guard++; end
    #1 rst = 1'b1;
    #1;
    check_eq("arst_pps", 32'(pps_out), 32'd0);
    check_eq("arst_sec", sec_count, 32'd0);
    check_eq("arst_rdy", 32'(adj_ready), 32'd1);
    model_reset();
    run(2);
    rst = 1'b0;
    run(5);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
      adj_valid = ($urandom_range(0, 9) == 0);
      v = int'($urandom_range(0, 600)) - 300;
      adj_value = AW'(v);
      step();
    end
    adj_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pps_generator.md
# pps_generator

Generates a 1PPS (one pulse per second) output from the fabric clock and is the transmit-side counterpart of `pps_receiver`. It is used to drive an external PPS pin or a downstream fabric timing domain. A free-running period counter produces a fixed-width pulse once per nominal second. Software or a disciplining loop can shorten or stretch exactly one period through a valid/ready phase-adjust handshake. A seconds counter and a single-cycle tick are also provided for the fabric.

## Interface
Parameters:
- `C_CLOCK_FREQUENCY`, default 125000. Clock cycles per nominal PPS period. Must be ≥ 2.
- `C_PULSE_WIDTH`, default 12500. Cycles that `pps_out` stays high. Must satisfy 1 ≤ value < `C_CLOCK_FREQUENCY`.
- `C_ADJ_WIDTH`, default 18. Width of the signed phase-adjust word.

Ports:
- `clk` in 1. Core clock. One clock; all logic is in this domain.
- `rst` in 1. Reset, asynchronous and active-high.
- `enable` in 1. Level input. 1 means generate pulses; 0 means idle.
- `adj_valid` in 1. Phase-adjust request.
- `adj_value` in `C_ADJ_WIDTH`. Signed cycle offset for one period.
- `adj_ready` out 1. High when the pending-adjust register is empty.
- `pps_out` out 1. PPS pulse, registered output.
- `pps_tick` out 1. Single-cycle strobe on the cycle `pps_out` rises.
- `sec_count` out 32. Number of pulses issued since reset.

## Operation
- States:
  - IDLE: `cnt` = 0, `pps_out` = 0.
  - RUN: `cnt` counts 0 … `period_cur`−1.
- IDLE→RUN: on the first edge where `enable` = 1. That edge loads `cnt` = 0 and sets `pps_out` = 1, `pps_tick` = 1, `sec_count` += 1. This edge is a *period start*.
- In RUN, each edge:
  - If `cnt` = `period_cur`−1, the edge is a period start: `cnt` ← 0.
  - Otherwise `cnt` ← `cnt`+1.
- `pps_out` on each edge:
  - Set to 1 at a period start.
  - Cleared on the edge where `cnt` goes from `C_PULSE_WIDTH`−1 to `C_PULSE_WIDTH`.
  - Result: high for exactly `C_PULSE_WIDTH` cycles.
- `period_cur` is loaded at every period start:
  - With the pending adjust, if one is held: `period_cur` = `C_CLOCK_FREQUENCY` + adj, and the pending flag is cleared.
  - Otherwise `period_cur` = `C_CLOCK_FREQUENCY`.
- Adjust arithmetic:
  - Signed, at width max(`C_ADJ_WIDTH`, clog2(2·`C_CLOCK_FREQUENCY`)) + 2.
  - Result saturates to [`C_PULSE_WIDTH`+1, 2·`C_CLOCK_FREQUENCY`−1].
  - `cnt` width is clog2(2·`C_CLOCK_FREQUENCY`).
- Adjust handshake:
  - Transfer occurs when `adj_valid` && `adj_ready` on an edge; `adj_value` is captured into the pending register.
  - `adj_ready` = !pending flag. It drops the cycle after the transfer and returns high the cycle after the consuming period start.
  - A transfer on a period-start edge does not affect the period beginning at that edge; it applies to the next one.
  - Adjusts may be accepted in IDLE. A pending adjust is retained across disable and applies to the first period after re-enable.
- Disable (`enable` = 0 in RUN):
  - Next edge: state ← IDLE, `cnt` ← 0, `pps_out` ← 0, even mid-pulse.
  - `sec_count` is retained.
  - Re-enable starts a fresh period start immediately; no phase continuity.
- `sec_count` wraps from 0xFFFFFFFF to 0.

## Timing
- All outputs are registered, except `adj_ready`, which is driven directly from the pending-flag register.
- Reset values: `pps_out` = 0, `pps_tick` = 0, `sec_count` = 0, `adj_ready` = 1. Reset also forces state IDLE, `cnt` = 0 and clears the pending flag.
- Assertion of `rst` forces these values immediately, without waiting for a clock edge, including mid-pulse.
- Latency from the enabling edge to `pps_out` = 1: zero additional cycles. The rise is registered on that same edge.
- In steady state, rising edges of `pps_out` are exactly `period_cur` cycles apart.
- `pps_tick` is coincident with the rising edge of `pps_out` and lasts one cycle.
- `sec_count` updates on the same edge as `pps_tick`.

## Test plan
All scenarios use `C_CLOCK_FREQUENCY` = 100 and `C_PULSE_WIDTH` = 10.
- **Basic run:** release reset, raise `enable` → `pps_out` rises on the first edge and stays high 10 cycles. Rises repeat every 100 cycles. `sec_count` reads 1, 2, 3 at successive ticks. `pps_tick` is exactly one cycle per rise.
- **Positive adjust:** `adj_value` = +5 accepted mid-period → next period is 105 cycles, the following one 100. `adj_ready` is low from the cycle after the accept until the cycle after the consuming tick.
- **Saturation:** `adj_value` = −200 → adjusted period is 11 cycles. `adj_value` = +500 → adjusted period is 199 cycles. Pulse width stays 10 in both cases.
- **Accept on tick:** `adj_valid` high on a period-start edge with `adj_value` = −3 → the period starting there is 100 cycles, the next one 97.
- **Disable:** `enable` dropped at `cnt` = 5 → `pps_out` is 0 the next cycle and `sec_count` holds. Re-enable 37 cycles later → immediate rise, and `sec_count` increments by 1.
- **Async reset:** `rst` pulsed mid-pulse between clock edges → `pps_out` = 0 and `sec_count` = 0 before the next edge, and `adj_ready` = 1.
